// File: rtl/demux_regfile_pkg.sv
// Shared constants and types for the demux register file.
// Index width is fixed at 5; register 31 is the hardwired zero register.
package regfile_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int NREG_DEF  = 32;
  localparam int IDX_W     = 5;
  localparam int XZR_IDX   = 31;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic logic is_xzr(idx_t i);
    return i == idx_t'(XZR_IDX);
  endfunction

endpackage

// File: rtl/demux_regfile_if.sv
// Write/read bus of the register file.
// The master drives indices and write data; the slave returns read data.
interface demux_regfile_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             RegWrite;
  idx_t             WriteRegister;
  logic [WIDTH-1:0] WriteData;
  idx_t             ReadRegister1;
  idx_t             ReadRegister2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;

  modport master (
    output RegWrite,
    output WriteRegister,
    output WriteData,
    output ReadRegister1,
    output ReadRegister2,
    input  ReadData1,
    input  ReadData2
  );

  modport slave (
    input  RegWrite,
    input  WriteRegister,
    input  WriteData,
    input  ReadRegister1,
    input  ReadRegister2,
    output ReadData1,
    output ReadData2
  );

endinterface

// File: rtl/demux_regfile_decoder.sv
// 5-to-32 one-hot decoder with enable.
// Drives the per-register load enables of the write path.
module decoder5_32
  import regfile_pkg::*;
(
  input  idx_t        idx_i,
  input  logic        en_i,
  output logic [31:0] onehot_o
);

  // One bit high for the selected index, all zero when disabled
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/demux_regfile.sv
// Register file with one-hot write demux, two combinational read ports,
// write-through bypass and a hardwired zero register at index 31.
module demux_regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREG  = NREG_DEF
) (
  input logic             clk,
  input logic             reset,
  demux_regfile_if.slave  bus
);

  logic [31:0]      dec;
  logic [NREG-1:0]  wen;
  logic             wr_en;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] mux1;
  logic [WIDTH-1:0] mux2;
  logic             byp1;
  logic             byp2;

  // Writes to XZR and writes under reset never reach the decoder
  assign wr_en = bus.RegWrite & ~reset
               & ~is_xzr(bus.WriteRegister);

  decoder5_32 u_dec (
    .idx_i    (bus.WriteRegister),
    .en_i     (wr_en),
    .onehot_o (dec)
  );

  assign wen = dec[NREG-1:0];

  // Next state: only the enabled register takes the write data
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = wen[i] ? bus.WriteData : regs_q[i];
    end
  end

  // Storage with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Read mux port 1; XZR and out-of-range indices read zero
  always_comb begin
    mux1 = '0;
    for (int i = 0; i < NREG; i++) begin
      if (i != XZR_IDX && bus.ReadRegister1 == idx_t'(i))
        mux1 = regs_q[i];
    end
  end

  // Read mux port 2; XZR and out-of-range indices read zero
  always_comb begin
    mux2 = '0;
    for (int i = 0; i < NREG; i++) begin
      if (i != XZR_IDX && bus.ReadRegister2 == idx_t'(i))
        mux2 = regs_q[i];
    end
  end

  assign byp1 = wr_en
              & (bus.WriteRegister == bus.ReadRegister1);
  assign byp2 = wr_en
              & (bus.WriteRegister == bus.ReadRegister2);

  // Reset forces zero; a matching write is forwarded same cycle
  always_comb begin
    bus.ReadData1 = '0;
    bus.ReadData2 = '0;
    if (!reset) begin
      bus.ReadData1 = byp1 ? bus.WriteData : mux1;
      bus.ReadData2 = byp2 ? bus.WriteData : mux2;
    end
  end

endmodule

// File: doc/demux_regfile.md
DEMUX_REGFILE -- requirements
Module: demux_regfile

Interface
REQ-001 Parameter WIDTH, default 64: data width of every register and data port.
REQ-002 Parameter NREG, default 32: number of architectural registers; index width is 5.
REQ-003 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 RegWrite  input  1  write enable for the current cycle.
REQ-006 WriteRegister  input  5  destination register index.
REQ-007 WriteData  input  WIDTH  data to be demultiplexed into the selected register.
REQ-008 ReadRegister1  input  5  index for read port 1.
REQ-009 ReadRegister2  input  5  index for read port 2.
REQ-010 ReadData1  output  WIDTH  read port 1 data, combinational.
REQ-011 ReadData2  output  WIDTH  read port 2 data, combinational.

Function
REQ-012 Write path SHALL decode WriteRegister to a one-hot enable vector of NREG bits, gated by RegWrite, so exactly zero or one register loads per cycle.
REQ-013 A selected register SHALL capture WriteData on the rising clk edge when its enable is high; all other registers SHALL hold their value.
REQ-014 Register 31 (XZR) SHALL always read as zero; writes to index 31 SHALL be discarded with no state change.
REQ-015 Read ports SHALL be combinational with zero-cycle latency from ReadRegisterN to ReadDataN.
REQ-016 Write-through bypass: when RegWrite=1, WriteRegister!=31, and WriteRegister==ReadRegisterN, ReadDataN SHALL equal WriteData in the same cycle.
REQ-017 With no matching write, ReadDataN SHALL equal the stored value of register ReadRegisterN, or zero for index 31.
REQ-018 Both read ports SHALL operate independently and may address the same register simultaneously with identical results.
REQ-019 Simultaneous write and read of index 31 SHALL return zero on the read port.
REQ-020 RegWrite=0 SHALL cause no state change regardless of WriteRegister and WriteData values.
REQ-021 Write-port latency SHALL be one cycle: the value is visible from storage on the cycle after the edge, and through the bypass on the cycle of the write.

Reset
REQ-022 Assertion of reset SHALL clear all NREG registers to zero immediately, independent of clk.
REQ-023 While reset is high, writes SHALL be ignored and both read ports SHALL output zero, including on a bypass match.
REQ-024 On reset deassertion, the first rising edge with RegWrite=1 SHALL perform a normal write.
REQ-025 Reset asserted mid-write SHALL abort the write, and the register SHALL remain zero.

Structure
REQ-026 A shared package regfile_pkg SHALL hold WIDTH_DEF=64, NREG_DEF=32, IDX_W=5, and XZR_IDX=31.
REQ-027 The write enable decoder SHALL be a sub-module decoder5_32: 5-bit index plus enable in, 32-bit one-hot out.
REQ-028 Storage SHALL be NREG WIDTH-bit registers with asynchronous reset; read selection SHALL be a 32:1 mux per port.

Verification
REQ-029 Reset pulse -> all reads on indices 0..31 return 0x0.
REQ-030 Write 0xDEADBEEF_CAFEF00D to X5, then read X5 on both ports the next cycle -> both ports return 0xDEADBEEF_CAFEF00D.
REQ-031 Write 0xFFFF_FFFF_FFFF_FFFF to X31 -> X31 reads 0x0, and registers X0..X30 are unchanged.
REQ-032 RegWrite=1, WriteRegister=7, WriteData=0x1234, ReadRegister1=7 in the same cycle -> ReadData1=0x1234 before the edge.
REQ-033 RegWrite=0 with WriteRegister=3 and WriteData=0xAA -> X3 keeps its prior value.
REQ-034 Assert reset between edges after writing X10=0x55 -> X10 reads 0x0 immediately, without waiting for a clock edge.
